// File: rtl/constregfile_banked_pe.sv
// rtl/constregfile_banked_pe.sv - double-banked PE constant register file with shadow load sequencer
module constregfile_banked_pe #(
    parameter int NUM_REGS       = 16,
    parameter int WRITE_DWIDTH   = 64,
    parameter int READ_DWIDTH    = 32,
    parameter int NUM_READ_PORTS = 2,
    parameter int WRITE_AWIDTH   = $clog2(NUM_REGS),
    parameter int READ_AWIDTH    = $clog2(NUM_REGS * (WRITE_DWIDTH / READ_DWIDTH))
) (
    input  logic                                  Clk,
    input  logic                                  Reset,
    input  logic                                  Load_Start,
    input  logic [WRITE_AWIDTH-1:0]               Load_Base,
    input  logic [WRITE_AWIDTH:0]                 Load_Count,
    input  logic                                  In_Valid,
    input  logic [WRITE_DWIDTH-1:0]               In_Const,
    output logic                                  In_Ready,
    output logic                                  Load_Busy,
    output logic                                  Shadow_Ready,
    input  logic                                  Swap,
    output logic                                  Active_Bank,
    input  logic [NUM_READ_PORTS-1:0]             Read_En,
    input  logic [NUM_READ_PORTS*READ_AWIDTH-1:0] Read_Addr,
    output logic [NUM_READ_PORTS*READ_DWIDTH-1:0] Read_Data
);

    // Slices per word, and helpers for splitting a slice address
    localparam int R      = WRITE_DWIDTH / READ_DWIDTH;
    localparam int R_LOG2 = $clog2(R);
    localparam int SHW    = (WRITE_DWIDTH > 1) ? $clog2(WRITE_DWIDTH) : 1;
    localparam logic [READ_AWIDTH-1:0] R_MASK = READ_AWIDTH'(R - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [WRITE_AWIDTH-1:0]   ptr_q, ptr_d;
    logic [WRITE_AWIDTH:0]     remaining_q, remaining_d;
    logic                      active_q, active_d;
    logic                      beat;

    // Two banks; the shadow bank is always the one not selected by active_q
    logic [WRITE_DWIDTH-1:0]   mem [2][NUM_REGS];

    assign beat         = (state_q == ST_LOAD) && In_Valid;
    assign In_Ready     = (state_q == ST_LOAD);
    assign Load_Busy    = (state_q == ST_LOAD);
    assign Shadow_Ready = (state_q == ST_READY);
    assign Active_Bank  = active_q;

    // Sequencer next-state: start a load, count beats, promote shadow on Swap
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        active_d    = active_q;
        case (state_q)
            ST_IDLE, ST_READY: begin
                // A new load always takes priority over a pending swap
                if (Load_Start) begin
                    if (Load_Count == '0) begin
                        state_d = ST_READY;
                    end else begin
                        state_d     = ST_LOAD;
                        ptr_d       = Load_Base;
                        remaining_d = Load_Count;
                    end
                end else if ((state_q == ST_READY) && Swap) begin
                    state_d  = ST_IDLE;
                    active_d = ~active_q;
                end
            end
            ST_LOAD: begin
                if (beat) begin
                    // Pointer width equals the index width, so it wraps modulo NUM_REGS
                    ptr_d       = ptr_q + WRITE_AWIDTH'(1);
                    remaining_d = remaining_q - (WRITE_AWIDTH + 1)'(1);
                    if (remaining_q == (WRITE_AWIDTH + 1)'(1)) begin
                        state_d = ST_READY;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer and bank-select registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            active_q    <= active_d;
        end
    end

    // Constant storage: reset clears both banks, load beats land in the shadow bank
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    mem[b][i] <= '0;
                end
            end
        end else if (beat) begin
            mem[~active_q][ptr_q] <= In_Const;
        end
    end

    // Zero-latency read ports from the active bank; slice 0 is the word's MSB slice
    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
        logic [READ_AWIDTH-1:0]  addr;
        logic [WRITE_AWIDTH-1:0] word_idx;
        logic [READ_AWIDTH-1:0]  slice_inv;
        logic [SHW-1:0]          shamt;
        logic [WRITE_DWIDTH-1:0] shifted;

        assign addr      = Read_Addr[p*READ_AWIDTH +: READ_AWIDTH];
        assign word_idx  = WRITE_AWIDTH'(addr >> R_LOG2);
        assign slice_inv = R_MASK - (addr & R_MASK);
        assign shamt     = SHW'(slice_inv) * SHW'(READ_DWIDTH);
        assign shifted   = mem[active_q][word_idx] >> shamt;
        assign Read_Data[p*READ_DWIDTH +: READ_DWIDTH] =
            Read_En[p] ? shifted[READ_DWIDTH-1:0] : '0;
    end

endmodule

// File: doc/constregfile_banked_pe.md
Name: constregfile_banked_pe

Overview:
- Next-generation PE constant register file for the CGRA: NUM_REGS wide constant words, split into READ_DWIDTH slices for the PE operand muxes.
- Two banks: active (read by the datapath) and shadow (loaded from the context/config stream via valid/ready).
- A load sequencer fills the shadow bank from a base/count descriptor while the PE keeps reading the active bank.
- A Swap request promotes the shadow bank with zero-bubble turnover between kernel iterations.

Parameters:
NUM_REGS, 16, constant words per bank (power of 2, >=2)
WRITE_DWIDTH, 64, width of one stored constant word
READ_DWIDTH, 32, width of one read slice; WRITE_DWIDTH/READ_DWIDTH = R, power of 2
NUM_READ_PORTS, 2, independent read ports
WRITE_AWIDTH, $clog2(NUM_REGS), word index width (derived)
READ_AWIDTH, $clog2(NUM_REGS*R), slice address width (derived)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
Load_Start  in  1  one-cycle request to begin a shadow-bank load
Load_Base  in  WRITE_AWIDTH  first word index of load, sampled with Load_Start
Load_Count  in  WRITE_AWIDTH+1  number of words to load (0..NUM_REGS), sampled with Load_Start
In_Valid  in  1  In_Const beat valid
In_Const  in  WRITE_DWIDTH  constant word beat
In_Ready  out  1  block accepts a beat this cycle
Load_Busy  out  1  sequencer in LOAD
Shadow_Ready  out  1  shadow bank complete, swap permitted
Swap  in  1  one-cycle request to exchange banks
Active_Bank  out  1  index of bank currently read
Read_En  in  NUM_READ_PORTS  per-port read enable
Read_Addr  in  NUM_READ_PORTS*READ_AWIDTH  per-port slice address, port p at [p*READ_AWIDTH +: READ_AWIDTH]
Read_Data  out  NUM_READ_PORTS*READ_DWIDTH  per-port data, same packing

Behaviour:
- Reset (Reset=0, async): both banks cleared to 0, Active_Bank=0, FSM=IDLE, In_Ready=0, Load_Busy=0, Shadow_Ready=0; Read_Data=0 while Read_En low.
- FSM states: IDLE, LOAD, READY (all state/flags are registered).
- IDLE:
  - Load_Start with Load_Count=0 -> READY.
  - Load_Start with Load_Count>0 -> LOAD; ptr<=Load_Base, remaining<=Load_Count.
  - Swap ignored.
- LOAD:
  - In_Ready=1, Load_Busy=1.
  - Beat = In_Valid & In_Ready: shadow[ptr]<=In_Const; ptr<=(ptr+1) mod NUM_REGS (wraps 15->0 at default); remaining--.
  - Beat with remaining==1 -> READY next cycle; In_Ready drops the cycle after the last beat.
  - Load_Start and Swap ignored in LOAD.
  - In_Valid low stalls with no timeout.
- READY:
  - Shadow_Ready=1.
  - Swap -> Active_Bank toggles at that edge, FSM->IDLE.
  - Load_Start (with or without Swap) -> reload as from IDLE; Load_Start wins over Swap, so no toggle.
- Shadow words not written by a load keep their prior contents; a partial load is an overlay.
- Swap takes effect on reads in the cycle after the Swap edge. Reads never observe shadow writes.
- Read path (combinational, zero latency from active bank):
  - word = addr / R, slice = addr mod R.
  - slice 0 = most significant READ_DWIDTH bits; e.g. default addr 2k -> [63:32], addr 2k+1 -> [31:0] of word k.
  - Read_En[p]=0 -> Read_Data[p]=0.
  - Ports are fully independent; same address on all ports is legal.
- Reset asserted mid-load or in READY aborts immediately to the reset state; the partial load is discarded (bank cleared).

Test Plan:
- Reset release, Read_En=11, addrs 0 and 31 -> Read_Data both 0, Active_Bank=0, In_Ready=0, Shadow_Ready=0.
- Load_Start base=0 count=2, beats 0x1111_2222_3333_4444 and 0x5555_6666_7777_8888, then Swap -> port0 addr1 reads 0x3333_4444, port1 addr2 reads 0x5555_6666, Active_Bank=1; before Swap, reads return 0.
- Load base=15 count=2, beats A then B with In_Valid gap of 3 cycles -> In_Ready held, shadow[15]=A, shadow[0]=B (wrap), Shadow_Ready asserts 1 cycle after second beat.
- Swap asserted during LOAD and on the last-beat cycle -> no bank toggle; Swap one cycle after Shadow_Ready -> toggle.
- Load_Count=0 -> READY next cycle with no In_Ready; Load_Start+Swap same cycle in READY -> enters LOAD, Active_Bank unchanged.
- Reset pulse after 1 of 4 beats -> all outputs at reset values, subsequent reads of every address 0 on both banks.
